seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Sequences the 6-digit multiplexed 7-segment display on the board.
- Holds a double-buffered 24-bit hex/BCD display value and time-slices the shared segment bus across digits.
- Inserts an anti-ghosting blank gap at the start of each digit slot, applies optional leading-zero blanking, and accepts new values via a req/ack handshake that commits only at frame boundaries.
- Sits between application logic (counters, clocks) and the digit-select/segment pins.

Parameters:
- NUM_DIGITS, 6: digits scanned per frame; fixes Column_Scan_Sig and Dp_In width.
- T_DWELL, 19'd499_999: terminal value of the slot counter. Slot = T_DWELL+1 cycles (10 ms at 50 MHz).
- BLANK_CYC, 19'd1000: cycles at slot start with all digits off. Must be < T_DWELL.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  synchronous reset, active-low.
- Data_In  in  24  six 4-bit nibbles; bits [3:0] = digit 0 (rightmost), bits [23:20] = digit 5.
- Dp_In  in  6  decimal point per digit, 1 = lit.
- Blank_En  in  1  1 = leading-zero blanking enabled.
- Load_Req  in  1  level; sampled each cycle; captures Data_In/Dp_In into the pending buffer.
- Load_Ack  out  1  one-cycle pulse when pending data is committed to the active buffer.
- Column_Scan_Sig  out  6  digit enables, active-low; bit i = digit i.
- Row_Scan_Sig  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- Frame_Done  out  1  one-cycle pulse at end of the digit-5 slot.

Behaviour:
- Clocking and reset:
  - All logic is on the rising edge of CLK.
  - Reset is synchronous and active-low: sampled on the CLK edge while RST_n = 0.
  - Reset values: count = 0, idx = 0, active buffer = 0, pending buffer = 0, pend_valid = 0.
  - Output reset values: Column_Scan_Sig = 6'h3F, Row_Scan_Sig = 8'hFF, Load_Ack = 0, Frame_Done = 0.
  - Reset mid-frame or mid-handshake discards pending data with no Load_Ack.
- Slot counter:
  - count runs 0..T_DWELL and wraps to 0.
  - At count == T_DWELL, idx advances 0→1→…→5→0.
  - The idx wrap cycle (idx == 5 and count == T_DWELL) is the frame boundary.
- Outputs (registered, one cycle after the count/idx state they reflect):
  - count < BLANK_CYC: Column_Scan_Sig = 6'h3F and Row_Scan_Sig = 8'hFF.
  - Otherwise: Column_Scan_Sig = ~(1 << idx), and Row_Scan_Sig = decode(active nibble[idx]) with dp bit = ~active_dp[idx].
- Decode (active-low, dp excluded, {g..a}):
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78.
  - 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Leading-zero blanking:
  - When Blank_En = 1 and idx > 0 and active nibbles idx..5 are all zero, segments g..a = 7'h7F.
  - The dp bit is still driven from active_dp.
  - Digit 0 is never blanked.
- Handshake:
  - Load_Req = 1 on any cycle: pending ← {Data_In, Dp_In}, pend_valid ← 1.
  - Latest request wins; overwriting an uncommitted pending value is legal.
  - At the frame boundary with pend_valid = 1: active ← pending, pend_valid ← 0, Load_Ack = 1 on the next cycle.
  - Load_Req on the boundary cycle itself: the new value goes to pending and commits at the following boundary; the old pending value commits now.
- Frame_Done: pulses on the cycle after the frame boundary, coincident with any Load_Ack.
- Widths and bounds:
  - count is 19 bits with no overflow beyond T_DWELL.
  - idx is 3 bits; values 6–7 are unreachable, and if reached the next cycle forces idx = 0 with outputs off.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS.
  - Segment encoding constants SEG_0..SEG_F and SEG_OFF = 7'h7F.
  - Default T_DWELL/BLANK_CYC.
- One combinational sub-module seg7_decode (4-bit in, 7-bit active-low out), instantiated once on the idx-selected nibble.

Test Plan:
All tests use T_DWELL = 9 and BLANK_CYC = 2.
1. Reset: hold RST_n = 0 for 3 cycles, release → Column_Scan_Sig = 6'h3F and Row_Scan_Sig = 8'hFF through the first 2 cycles of slot 0, then Column_Scan_Sig = 6'h3E; Row_Scan_Sig = 8'hC0 (0, dp off).
2. Load and commit: Load_Req pulse with Data_In = 24'h123456, Dp_In = 6'b000100 mid-slot 2 → no change until the frame boundary; then Load_Ack and Frame_Done pulse together; digit 0 shows 8'h82 (6), digit 2 shows 8'h19 (4, dp lit).
3. Leading-zero blanking: Data_In = 24'h000120, Blank_En = 1 → digits 3–5 drive 8'hFF while enabled, digit 0 shows 8'hC0; with Blank_En = 0, digits 3–5 show 8'hC0.
4. Overwrite and boundary race: Load_Req with 24'h111111, then 24'h222222 before the boundary → only 222222 displayed, a single Load_Ack; a Load_Req on the boundary cycle commits one frame later.
5. Scan order and wrap: free-run 2 frames → Column_Scan_Sig sequence 3E,3D,3B,37,2F,1F,3E, with the 3F gap of exactly 2 cycles before each; Frame_Done every 60 cycles.
6. Reset mid-operation: assert RST_n = 0 with pend_valid = 1 in slot 4 → outputs return to reset values, no Load_Ack, and the active value is 0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Slot length and blanking gap defaults (50 MHz clock, 10 ms slot).
  localparam logic [18:0] T_DWELL_DEF   = 19'd499_999;
  localparam logic [18:0] BLANK_CYC_DEF = 19'd1000;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_scan_ctrl_seg7_decode.sv
// Hex nibble to active-low 7-segment pattern (dp handled by the caller).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; every nibble value has a glyph.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-slices a double-buffered 6-digit value onto the shared segment bus,
// with a blank gap at each slot start, leading-zero blanking and a
// req/ack load that only commits on frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter logic [18:0] T_DWELL   = T_DWELL_DEF,
  parameter logic [18:0] BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [23:0] Data_In,
  input  logic [5:0]  Dp_In,
  input  logic        Blank_En,
  input  logic        Load_Req,
  output logic        Load_Ack,
  output logic [5:0]  Column_Scan_Sig,
  output logic [7:0]  Row_Scan_Sig,
  output logic        Frame_Done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [18:0] count_reg, count_next;
  logic [2:0]  idx_reg, idx_next;
  logic [23:0] act_data_reg, act_data_next;
  logic [5:0]  act_dp_reg, act_dp_next;
  logic [23:0] pend_data_reg, pend_data_next;
  logic [5:0]  pend_dp_reg, pend_dp_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [5:0]  col_reg, col_next;
  logic [7:0]  row_reg, row_next;
  logic        ack_reg, ack_next;
  logic        fd_reg, fd_next;

  logic                  idx_valid;
  logic                  boundary;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_lz_blank;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] upper_zero;

  assign idx_valid = (idx_reg <= LAST_IDX);
  assign boundary  = (idx_reg == LAST_IDX) && (count_reg == T_DWELL);

  // upper_zero[i]: every active nibble from digit i up to the top is zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (act_data_reg[4*gi +: 4*(NUM_DIGITS-gi)] == '0);
    end
  endgenerate

  // Select the nibble, dp and blanking flag of the digit being scanned.
  always_comb begin
    cur_nibble   = 4'h0;
    cur_dp       = 1'b0;
    cur_lz_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == 3'(i)) begin
        cur_nibble   = act_data_reg[4*i +: 4];
        cur_dp       = act_dp_reg[i];
        cur_lz_blank = (i != 0) && upper_zero[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Slot/digit sequencing, buffer handshake and next registered outputs.
  always_comb begin
    count_next      = count_reg;
    idx_next        = idx_reg;
    act_data_next   = act_data_reg;
    act_dp_next     = act_dp_reg;
    pend_data_next  = pend_data_reg;
    pend_dp_next    = pend_dp_reg;
    pend_valid_next = pend_valid_reg;
    col_next        = 6'h3F;
    row_next        = 8'hFF;
    ack_next        = 1'b0;
    fd_next         = 1'b0;

    if (!idx_valid) begin
      // Recover from an illegal digit index with the display off.
      count_next = '0;
      idx_next   = '0;
    end else if (count_reg >= T_DWELL) begin
      count_next = '0;
      idx_next   = (idx_reg == LAST_IDX) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      count_next = count_reg + 19'd1;
    end

    if (Load_Req) begin
      pend_data_next  = Data_In;
      pend_dp_next    = Dp_In;
      pend_valid_next = 1'b1;
    end

    // The old pending value commits; a same-cycle request stays pending.
    if (boundary) begin
      fd_next = 1'b1;
      if (pend_valid_reg) begin
        act_data_next = pend_data_reg;
        act_dp_next   = pend_dp_reg;
        ack_next      = 1'b1;
        if (!Load_Req) begin
          pend_valid_next = 1'b0;
        end
      end
    end

    if (idx_valid && (count_reg >= BLANK_CYC)) begin
      col_next = ~(6'd1 << idx_reg);
      row_next = {~cur_dp, (Blank_En && cur_lz_blank) ? SEG_OFF : cur_seg};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      count_reg      <= '0;
      idx_reg        <= '0;
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_valid_reg <= 1'b0;
      col_reg        <= 6'h3F;
      row_reg        <= 8'hFF;
      ack_reg        <= 1'b0;
      fd_reg         <= 1'b0;
    end else begin
      count_reg      <= count_next;
      idx_reg        <= idx_next;
      act_data_reg   <= act_data_next;
      act_dp_reg     <= act_dp_next;
      pend_data_reg  <= pend_data_next;
      pend_dp_reg    <= pend_dp_next;
      pend_valid_reg <= pend_valid_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      ack_reg        <= ack_next;
      fd_reg         <= fd_next;
    end
  end

  assign Column_Scan_Sig = col_reg;
  assign Row_Scan_Sig    = row_reg;
  assign Load_Ack        = ack_reg;
  assign Frame_Done      = fd_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 10-cycle slot and 2-cycle gap.
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [23:0] Data_In;
  logic [5:0]  Dp_In;
  logic        Blank_En;
  logic        Load_Req;
  logic        Load_Ack;
  logic [5:0]  Column_Scan_Sig;
  logic [7:0]  Row_Scan_Sig;
  logic        Frame_Done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0]     data;
    logic [5:0]      dp;
    logic            blank;
    logic [5:0][7:0] exp_row;   // index = digit
  } vec_t;

  vec_t vecs [5];

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(
    .T_DWELL   (19'd9),
    .BLANK_CYC (19'd2)
  ) dut (
    .CLK             (CLK),
    .RST_n           (RST_n),
    .Data_In         (Data_In),
    .Dp_In           (Dp_In),
    .Blank_En        (Blank_En),
    .Load_Req        (Load_Req),
    .Load_Ack        (Load_Ack),
    .Column_Scan_Sig (Column_Scan_Sig),
    .Row_Scan_Sig    (Row_Scan_Sig),
    .Frame_Done      (Frame_Done)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Advance until Frame_Done is seen (bounded); no ack may appear before it.
  task automatic wait_frame_done(output logic ack_seen);
    logic done;
    logic early;
    done     = 1'b0;
    early    = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      if (Load_Ack && !Frame_Done) early = 1'b1;
      if (Frame_Done) begin
        done     = 1'b1;
        ack_seen = Load_Ack;
      end
    end
    check8("early_ack", {7'b0, early}, 8'h00);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout got none expected pulse within 200 cycles");
    end
  endtask

  // Called on the Frame_Done cycle; samples each digit mid-slot, ends 5 cycles before the next boundary pulse.
  task automatic check_digits(input string tag, input logic [5:0][7:0] exp);
    logic [5:0] ec;
    step(5);
    for (int d = 0; d < 6; d++) begin
      if (d > 0) step(10);
      ec = ~(6'd1 << d);
      check8($sformatf("%s_col%0d", tag, d), {2'b00, Column_Scan_Sig}, {2'b00, ec});
      check8($sformatf("%s_row%0d", tag, d), Row_Scan_Sig, exp[d]);
    end
  endtask

  task automatic load(input logic [23:0] d, input logic [5:0] p);
    Data_In  = d;
    Dp_In    = p;
    Load_Req = 1'b1;
    step(1);
    Load_Req = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [5:0] ec;
    int         pos;
    int         slot;

    vecs[0] = '{24'h000120, 6'h00, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0}};
    vecs[1] = '{24'h000120, 6'h00, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hC0}};
    vecs[2] = '{24'hABCDEF, 6'h3F, 1'b1, {8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E}};
    vecs[3] = '{24'h000000, 6'h21, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40}};
    vecs[4] = '{24'h789000, 6'h00, 1'b1, {8'hF8, 8'h80, 8'h90, 8'hC0, 8'hC0, 8'hC0}};

    RST_n    = 1'b0;
    Data_In  = '0;
    Dp_In    = '0;
    Blank_En = 1'b0;
    Load_Req = 1'b0;

    // Reset values, then the 2-cycle gap before digit 0.
    step(3);
    check8("rst_col", {2'b00, Column_Scan_Sig}, 8'h3F);
    check8("rst_row", Row_Scan_Sig, 8'hFF);
    check8("rst_ack", {7'b0, Load_Ack}, 8'h00);
    check8("rst_fd",  {7'b0, Frame_Done}, 8'h00);
    RST_n = 1'b1;
    step(1);
    check8("gap0_col", {2'b00, Column_Scan_Sig}, 8'h3F);
    check8("gap0_row", Row_Scan_Sig, 8'hFF);
    step(1);
    check8("gap1_col", {2'b00, Column_Scan_Sig}, 8'h3F);
    step(1);
    check8("d0_col", {2'b00, Column_Scan_Sig}, 8'h3E);
    check8("d0_row", Row_Scan_Sig, 8'hC0);

    // Load mid-slot 2: nothing changes until the boundary.
    wait_frame_done(ack);
    check8("first_frame_ack", {7'b0, ack}, 8'h00);
    step(25);
    load(24'h123456, 6'b000100);
    check8("preload_col", {2'b00, Column_Scan_Sig}, 8'h3B);
    check8("preload_row", Row_Scan_Sig, 8'hC0);
    wait_frame_done(ack);
    check8("load_ack", {7'b0, ack}, 8'h01);
    check_digits("v123456", {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82});

    // Table of values with blanking on/off and dp patterns.
    for (int v = 0; v < 5; v++) begin
      Blank_En = vecs[v].blank;
      load(vecs[v].data, vecs[v].dp);
      wait_frame_done(ack);
      check8($sformatf("vec%0d_ack", v), {7'b0, ack}, 8'h01);
      check_digits($sformatf("vec%0d", v), vecs[v].exp_row);
    end

    // Overwrite before the boundary: only the latest value, one ack.
    Blank_En = 1'b0;
    load(24'h111111, 6'h00);
    step(2);
    load(24'h222222, 6'h00);
    wait_frame_done(ack);
    check8("ovr_ack", {7'b0, ack}, 8'h01);
    check_digits("ovr", {8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4});
    wait_frame_done(ack);
    check8("ovr_single_ack", {7'b0, ack}, 8'h00);

    // Request on the boundary cycle: older pending commits now, new one next frame.
    step(50);
    load(24'h444444, 6'h00);
    step(8);
    Data_In  = 24'h333333;
    Load_Req = 1'b1;
    step(1);
    Load_Req = 1'b0;
    check8("race_fd",  {7'b0, Frame_Done}, 8'h01);
    check8("race_ack", {7'b0, Load_Ack}, 8'h01);
    check_digits("race4", {8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99});
    wait_frame_done(ack);
    check8("race_next_ack", {7'b0, ack}, 8'h01);
    check_digits("race3", {8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0});

    // Full-frame scan order, blank gaps and Frame_Done period.
    wait_frame_done(ack);
    for (int i = 1; i <= 60; i++) begin
      step(1);
      pos  = (i - 1) % 10;
      slot = (i - 1) / 10;
      ec   = (pos < 2) ? 6'h3F : ~(6'd1 << slot);
      check8($sformatf("scan%0d_col", i), {2'b00, Column_Scan_Sig}, {2'b00, ec});
      check8($sformatf("scan%0d_fd", i), {7'b0, Frame_Done}, (i == 60) ? 8'h01 : 8'h00);
    end

    // Reset with a pending value in slot 4: discarded, no ack.
    step(42);
    load(24'h555555, 6'h3F);
    step(2);
    RST_n = 1'b0;
    step(2);
    check8("mrst_col", {2'b00, Column_Scan_Sig}, 8'h3F);
    check8("mrst_row", Row_Scan_Sig, 8'hFF);
    check8("mrst_ack", {7'b0, Load_Ack}, 8'h00);
    check8("mrst_fd",  {7'b0, Frame_Done}, 8'h00);
    RST_n = 1'b1;
    wait_frame_done(ack);
    check8("mrst_no_ack", {7'b0, ack}, 8'h00);
    check_digits("mrst", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
